// File: rtl/button_pkg.sv
// Shared constants for the button input peripheral: register map, flag bit
// positions and the counter-width helper used by the debounce block.
package button_pkg;

  localparam logic [1:0] MODE_ADDR   = 2'd0;
  localparam logic [1:0] TRIP_ADDR   = 2'd1;
  localparam logic [1:0] STATUS_ADDR = 2'd2;

  localparam int PRESS_BIT = 0;
  localparam int LONG_BIT  = 1;

  localparam logic [1:0] HTRANS_IDLE = 2'b00;

  typedef struct packed {
    logic long_hold;
    logic press;
  } btn_flags_t;

  // A counter for a limit of 1 still needs one bit to exist.
  function automatic int cnt_width(input int limit);
    return (limit > 1) ? $clog2(limit) : 1;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// One button channel: two-flop synchroniser, debounce counter and hold counter.
// press_pulse/long_pulse are high in the cycle before the edge that sets the flag.
module button_debounce
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = 164,
  parameter int LONG_PRESS_CYCLES = 32768
) (
  input  logic clk_sys,
  input  logic rst_b,
  input  logic btn_n,
  output logic level,
  output logic press_pulse,
  output logic long_pulse
);

  localparam int DW = cnt_width(DEBOUNCE_CYCLES);
  localparam int HW = cnt_width(LONG_PRESS_CYCLES);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_PRESS_CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          level_q, level_d;
  logic [DW-1:0] deb_cnt_q, deb_cnt_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic          pressed_s;
  logic          toggle;

  always_comb begin
    sync1_d   = btn_n;
    sync2_d   = sync1_q;
    pressed_s = ~sync2_q;

    toggle    = 1'b0;
    level_d   = level_q;
    deb_cnt_d = '0;
    if (pressed_s != level_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        toggle  = 1'b1;
        level_d = ~level_q;
      end else begin
        deb_cnt_d = deb_cnt_q + DW'(1);
      end
    end

    // Saturating at the terminal value is what stops the long flag retriggering.
    hold_cnt_d = '0;
    if (level_q) begin
      hold_cnt_d = (hold_cnt_q == HOLD_LAST) ? hold_cnt_q : hold_cnt_q + HW'(1);
    end
  end

  always_ff @(posedge clk_sys or negedge rst_b) begin
    if (!rst_b) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      level_q    <= 1'b0;
      deb_cnt_q  <= '0;
      hold_cnt_q <= '0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      level_q    <= level_d;
      deb_cnt_q  <= deb_cnt_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign level       = level_q;
  assign press_pulse = toggle & ~level_q;
  assign long_pulse  = level_q & (hold_cnt_q != HOLD_LAST) & (hold_cnt_d == HOLD_LAST);

endmodule

// File: rtl/button_manager.sv
// AHB-Lite slave exposing debounced Mode/Trip buttons as sticky, clear-on-read
// press and long-press flags plus a live level status register.
module button_manager
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = 164,
  parameter int LONG_PRESS_CYCLES = 32768
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic [31:0] HADDR,
  input  logic [31:0] HWDATA,
  input  logic        HWRITE,
  input  logic        HREADY,
  input  logic        HSEL,
  input  logic [2:0]  HSIZE,
  input  logic [1:0]  HTRANS,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  input  logic        nMode,
  input  logic        nTrip,
  output logic        ButtonEvent
);

  logic       read_q, read_d;
  logic [1:0] sel_q, sel_d;
  btn_flags_t mode_flags_q, mode_flags_d;
  btn_flags_t trip_flags_q, trip_flags_d;

  logic addr_valid;
  logic clr_mode, clr_trip;
  logic mode_level, mode_press, mode_long;
  logic trip_level, trip_press, trip_long;
  logic unused_ok;

  button_debounce #(
    .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
    .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES)
  ) u_mode (
    .clk_sys    (HCLK),
    .rst_b      (HRESETn),
    .btn_n      (nMode),
    .level      (mode_level),
    .press_pulse(mode_press),
    .long_pulse (mode_long)
  );

  button_debounce #(
    .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
    .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES)
  ) u_trip (
    .clk_sys    (HCLK),
    .rst_b      (HRESETn),
    .btn_n      (nTrip),
    .level      (trip_level),
    .press_pulse(trip_press),
    .long_pulse (trip_long)
  );

  always_comb begin
    addr_valid = HSEL && HREADY && (HTRANS != HTRANS_IDLE);
    read_d     = addr_valid && !HWRITE;
    sel_d      = addr_valid ? HADDR[3:2] : sel_q;

    clr_mode = read_q && HREADY && (sel_q == MODE_ADDR);
    clr_trip = read_q && HREADY && (sel_q == TRIP_ADDR);

    // A set arriving on the clearing edge wins so no press is ever lost.
    mode_flags_d.press     = mode_press | (mode_flags_q.press     & ~clr_mode);
    mode_flags_d.long_hold = mode_long  | (mode_flags_q.long_hold & ~clr_mode);
    trip_flags_d.press     = trip_press | (trip_flags_q.press     & ~clr_trip);
    trip_flags_d.long_hold = trip_long  | (trip_flags_q.long_hold & ~clr_trip);
  end

  always_comb begin
    HRDATA = '0;
    if (read_q) begin
      case (sel_q)
        MODE_ADDR: begin
          HRDATA[PRESS_BIT] = mode_flags_q.press;
          HRDATA[LONG_BIT]  = mode_flags_q.long_hold;
        end
        TRIP_ADDR: begin
          HRDATA[PRESS_BIT] = trip_flags_q.press;
          HRDATA[LONG_BIT]  = trip_flags_q.long_hold;
        end
        STATUS_ADDR: begin
          HRDATA[0] = mode_level;
          HRDATA[1] = trip_level;
        end
        default: HRDATA = '0;
      endcase
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      read_q       <= 1'b0;
      sel_q        <= '0;
      mode_flags_q <= '0;
      trip_flags_q <= '0;
    end else begin
      read_q       <= read_d;
      sel_q        <= sel_d;
      mode_flags_q <= mode_flags_d;
      trip_flags_q <= trip_flags_d;
    end
  end

  assign HREADYOUT   = 1'b1;
  assign ButtonEvent = |{mode_flags_q, trip_flags_q};

  // Write data, transfer size and unused address bits carry no meaning here.
  assign unused_ok = ^{HWDATA, HSIZE, HADDR[31:4], HADDR[1:0]};

endmodule
